// File: rtl/trig_pkg.sv
// Shared types and default timing constants for the button trigger conditioner (50 MHz clk).
package trig_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    STRETCH  = 2'd1,
    WAIT_REL = 2'd2
  } trig_state_t;

  localparam int DEF_DEBOUNCE_CYCLES = 1_000_000;    // 20 ms
  localparam int DEF_STRETCH_CYCLES  = 20_000_000;   // > 2^24 so div[23] always sees it
  localparam int DEF_LONG_CYCLES     = 100_000_000;  // 2 s
  localparam int DEF_CNT_W           = 8;

endpackage

// File: rtl/btn_debouncer.sv
// Level debouncer: dout follows din_s only after din_s has differed for DEBOUNCE_CYCLES clocks.
module btn_debouncer
  import trig_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
  input  logic clk,
  input  logic reset,
  input  logic din_s,
  output logic dout
);

  localparam int            CW       = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [CW-1:0] cnt;

  // Any return to the accepted level clears the count, so glitches restart the window.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt  <= '0;
      dout <= 1'b0;
    end else if (din_s == dout) begin
      cnt <= '0;
    end else if (cnt == CNT_LAST) begin
      dout <= din_s;
      cnt  <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/trigger_conditioner.sv
// Button -> sync -> debounce -> edge detect -> pulse stretcher, plus saturating press counter.
// Define LONG_PRESS_EN to build the long-press detector; otherwise long_pulse is tied low.
module trigger_conditioner
  import trig_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int STRETCH_CYCLES  = DEF_STRETCH_CYCLES,
  parameter int LONG_CYCLES     = DEF_LONG_CYCLES,
  parameter int CNT_W           = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             btn_raw,
  output logic             pressed,
  output logic             press_pulse,
  output logic             trigger,
  output logic             busy,
  output logic [CNT_W-1:0] press_count,
  output logic             long_pulse
);

  localparam int            SW           = $clog2(STRETCH_CYCLES + 1);
  localparam logic [SW-1:0] STRETCH_LAST = SW'(STRETCH_CYCLES - 1);

  if (DEBOUNCE_CYCLES < 1 || STRETCH_CYCLES < 1 || LONG_CYCLES < 1 || CNT_W < 1) begin : g_param_check
    $error("trigger_conditioner: cycle parameters and CNT_W must be >= 1");
  end

  logic          sync1, btn_s;
  logic          pressed_q;
  trig_state_t   state;
  logic [SW-1:0] scnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1 <= 1'b0;
      btn_s <= 1'b0;
    end else begin
      sync1 <= btn_raw;
      btn_s <= sync1;
    end
  end

  btn_debouncer #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_debouncer (
    .clk  (clk),
    .reset(reset),
    .din_s(btn_s),
    .dout (pressed)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pressed_q   <= 1'b0;
      press_pulse <= 1'b0;
      press_count <= '0;
    end else begin
      pressed_q   <= pressed;
      press_pulse <= pressed & ~pressed_q;
      if (press_pulse && press_count != '1)
        press_count <= press_count + 1'b1;
    end
  end

  // Only IDLE looks at press_pulse, so presses during STRETCH/WAIT_REL never retrigger.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      scnt    <= '0;
      trigger <= 1'b0;
      busy    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (press_pulse) begin
            state   <= STRETCH;
            scnt    <= STRETCH_LAST;
            trigger <= 1'b1;
            busy    <= 1'b1;
          end
        end
        STRETCH: begin
          if (scnt == '0) begin
            trigger <= 1'b0;
            if (pressed) begin
              state <= WAIT_REL;
            end else begin
              state <= IDLE;
              busy  <= 1'b0;
            end
          end else begin
            scnt <= scnt - 1'b1;
          end
        end
        WAIT_REL: begin
          if (!pressed) begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        default: begin
          state   <= IDLE;
          trigger <= 1'b0;
          busy    <= 1'b0;
        end
      endcase
    end
  end

`ifdef LONG_PRESS_EN
  localparam int            HW        = $clog2(LONG_CYCLES + 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(LONG_CYCLES - 1);
  localparam logic [HW-1:0] HOLD_DONE = HW'(LONG_CYCLES);

  logic [HW-1:0] hold_cnt;

  // Counter parks at LONG_CYCLES after firing, giving one long_pulse per press.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hold_cnt   <= '0;
      long_pulse <= 1'b0;
    end else if (!pressed) begin
      hold_cnt   <= '0;
      long_pulse <= 1'b0;
    end else begin
      long_pulse <= (hold_cnt == HOLD_LAST);
      if (hold_cnt != HOLD_DONE)
        hold_cnt <= hold_cnt + 1'b1;
    end
  end
`else
  assign long_pulse = 1'b0;
`endif

endmodule

// File: tb/tb_trigger_conditioner.sv
// Directed bench for trigger_conditioner with small cycle parameters (4/8/16, CNT_W=3).
module tb_trigger_conditioner;

`ifdef LONG_PRESS_EN
  localparam logic LP = 1'b1;
`else
  localparam logic LP = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset;
  logic       btn_raw;
  logic       pressed, press_pulse, trigger, busy, long_pulse;
  logic [2:0] press_count;

  int n_pass  = 0;
  int n_total = 0;

  typedef struct {
    int         len;
    logic       btn;
    logic       p, pu, t, b;
    logic [2:0] c;
    logic       l;
  } seg_t;

  seg_t tab[$];

  always #5 clk = ~clk;

  trigger_conditioner #(
    .DEBOUNCE_CYCLES(4),
    .STRETCH_CYCLES (8),
    .LONG_CYCLES    (16),
    .CNT_W          (3)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .btn_raw    (btn_raw),
    .pressed    (pressed),
    .press_pulse(press_pulse),
    .trigger    (trigger),
    .busy       (busy),
    .press_count(press_count),
    .long_pulse (long_pulse)
  );

  task automatic chk(input string nm, input int stp, input logic [7:0] act, input logic [7:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s @step %0d: got %0d expected %0d", nm, stp, act, exp);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, ".pressed"},     0, 8'(pressed),     8'd0);
    chk({tag, ".press_pulse"}, 0, 8'(press_pulse), 8'd0);
    chk({tag, ".trigger"},     0, 8'(trigger),     8'd0);
    chk({tag, ".busy"},        0, 8'(busy),        8'd0);
    chk({tag, ".press_count"}, 0, 8'(press_count), 8'd0);
    chk({tag, ".long_pulse"},  0, 8'(long_pulse),  8'd0);
  endtask

  // One step: drive btn_raw, take one rising edge, sample 1 ns later.
  task automatic step(input logic b);
    btn_raw = b;
    @(posedge clk);
    #1;
  endtask

  function automatic void add(input int len, input logic b, input logic p, input logic pu,
                              input logic t, input logic bz, input int c, input logic l);
    tab.push_back('{len, b, p, pu, t, bz, 3'(c), l});
  endfunction

  task automatic run_range(input string tag, input int first, input int last);
    int s = 0;
    for (int i = first; i < last; i++) begin
      for (int k = 0; k < tab[i].len; k++) begin
        s++;
        step(tab[i].btn);
        chk({tag, ".pressed"},     s, 8'(pressed),     8'(tab[i].p));
        chk({tag, ".press_pulse"}, s, 8'(press_pulse), 8'(tab[i].pu));
        chk({tag, ".trigger"},     s, 8'(trigger),     8'(tab[i].t));
        chk({tag, ".busy"},        s, 8'(busy),        8'(tab[i].b));
        chk({tag, ".press_count"}, s, 8'(press_count), 8'(tab[i].c));
        chk({tag, ".long_pulse"},  s, 8'(long_pulse),  8'(tab[i].l));
      end
    end
  endtask

  initial begin
    int t1a, t1b, t2a, t2b, t3a, t3b, t6a, t6b;

    // T1 clean press: pressed @6, pulse @7, trigger 8..15, WAIT_REL until release.
    t1a = tab.size();
    add(5, 1, 0, 0, 0, 0, 0, 0);
    add(1, 1, 1, 0, 0, 0, 0, 0);
    add(1, 1, 1, 1, 0, 0, 0, 0);
    add(8, 1, 1, 0, 1, 1, 1, 0);
    add(5, 1, 1, 0, 0, 1, 1, 0);
    add(1, 0, 1, 0, 0, 1, 1, 0);
    add(1, 0, 1, 0, 0, 1, 1, LP);
    add(3, 0, 1, 0, 0, 1, 1, 0);
    add(1, 0, 0, 0, 0, 1, 1, 0);
    add(4, 0, 0, 0, 0, 0, 1, 0);
    t1b = tab.size();

    // T2 bounce every 2 cycles: nothing may be accepted.
    t2a = tab.size();
    for (int i = 0; i < 5; i++) begin
      add(2, 1, 0, 0, 0, 0, 1, 0);
      add(2, 0, 0, 0, 0, 0, 1, 0);
    end
    add(10, 0, 0, 0, 0, 0, 1, 0);
    t2b = tab.size();

    // T3 second press pulses at step 15 while trigger still high: counted, no extension.
    t3a = tab.size();
    add(4, 1, 0, 0, 0, 0, 1, 0);
    add(1, 0, 0, 0, 0, 0, 1, 0);
    add(1, 0, 1, 0, 0, 0, 1, 0);
    add(1, 0, 1, 1, 0, 0, 1, 0);
    add(1, 0, 1, 0, 1, 1, 2, 0);
    add(1, 1, 1, 0, 1, 1, 2, 0);
    add(4, 1, 0, 0, 1, 1, 2, 0);
    add(1, 1, 1, 0, 1, 1, 2, 0);
    add(1, 1, 1, 1, 1, 1, 2, 0);
    add(4, 1, 1, 0, 0, 1, 3, 0);
    add(5, 0, 1, 0, 0, 1, 3, 0);
    add(1, 0, 0, 0, 0, 1, 3, 0);
    add(4, 0, 0, 0, 0, 0, 3, 0);
    t3b = tab.size();

    // T6 hold ~30 cycles: long_pulse (if built) exactly at step 22.
    t6a = tab.size();
    add(5, 1, 0, 0, 0, 0, 1, 0);
    add(1, 1, 1, 0, 0, 0, 1, 0);
    add(1, 1, 1, 1, 0, 0, 1, 0);
    add(8, 1, 1, 0, 1, 1, 2, 0);
    add(6, 1, 1, 0, 0, 1, 2, 0);
    add(1, 1, 1, 0, 0, 1, 2, LP);
    add(8, 1, 1, 0, 0, 1, 2, 0);
    add(5, 0, 1, 0, 0, 1, 2, 0);
    add(1, 0, 0, 0, 0, 1, 2, 0);
    add(4, 0, 0, 0, 0, 0, 2, 0);
    t6b = tab.size();

    reset   = 1'b1;
    btn_raw = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk_all_zero("reset");
    reset = 1'b0;

    run_range("T1", t1a, t1b);
    run_range("T2", t2a, t2b);
    run_range("T3", t3a, t3b);

    reset = 1'b1;
    #1;
    chk("rst2.press_count", 0, 8'(press_count), 8'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;

    // T4 saturation: nine separated presses, count clamps at 7.
    for (int i = 1; i <= 9; i++) begin
      repeat (6) step(1'b1);
      repeat (14) step(1'b0);
      chk("T4.press_count", i, 8'(press_count), 8'(i < 7 ? i : 7));
    end

    // T5 reset three cycles into trigger high; outputs drop without a clock edge.
    repeat (10) step(1'b1);
    chk("T5.trigger_pre", 10, 8'(trigger), 8'd1);
    chk("T5.busy_pre",    10, 8'(busy),    8'd1);
    #2;
    reset = 1'b1;
    #1;
    chk_all_zero("T5.async");
    btn_raw = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    run_range("T5.replay", t1a, t1b);

    run_range("T6", t6a, t6b);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
